// File: rtl/simon_decrypt.sv
// Serial Simon32/64 decryption engine: loads ciphertext nibbles and key bytes over 8 beats,
// expands the key schedule forward, runs 32 inverse rounds walking the schedule backward, streams plaintext.
module simon_decrypt #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4,
  parameter int unsigned C = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] key,
  input  logic [M-1:0] ciphertxt,
  input  logic         start,
  output logic [M-1:0] plain,
  output logic         plain_valid,
  output logic         busy,
  output logic         done_final
);

  localparam int unsigned KW = N * C;
  localparam int unsigned BW = M * C;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_BEAT = CW'(C - 1);
  localparam logic [CW-1:0] LAST_EXP  = CW'(27);
  localparam logic [CW-1:0] LAST_RND  = CW'(31);
  // z0 sequence, index 0 at bit 63; padded so any 6-bit index stays in range
  localparam logic [63:0] Z0 =
    {62'b11111010001001010110000111001101111101000100101011000011100110, 2'b00};

  typedef enum logic [2:0] {IDLE, LOAD, EXPAND, DECRYPT, OUTPUT, DONE} state_e;

  function automatic logic [15:0] sched_t(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    t = {a[2:0], a[15:3]} ^ b;
    return t ^ {t[0], t[15:1]};
  endfunction

  function automatic logic [15:0] round_f(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  function automatic logic [15:0] zword(input logic [5:0] idx);
    return {15'b0, Z0[6'd63 - idx]};
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   ct_q, ct_d;
  logic [KW-1:0]   key_q, key_d;
  logic [M-1:0]    plain_q, plain_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  logic [15:0]     w3, w2, w1, w0;
  logic [15:0]     exp_new, bwd_prev;
  logic [BW-1:0]   rnd_data;

  // Key window w3..w0: k_{i+3}..k_i while expanding, k_i..k_{i-3} while decrypting
  assign w3 = key_q[63:48];
  assign w2 = key_q[47:32];
  assign w1 = key_q[31:16];
  assign w0 = key_q[15:0];

  assign exp_new  = ~w0 ^ sched_t(w3, w1) ^ zword(6'(cnt_q)) ^ 16'h0003;
  assign bwd_prev = ~(w3 ^ sched_t(w2, w0) ^ zword(6'(cnt_q) - 6'd4) ^ 16'h0003);
  assign rnd_data = {ct_q[15:0], ct_q[31:16] ^ round_f(ct_q[15:0]) ^ w3};

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    key_d   = key_q;
    plain_d = plain_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ct_d    = {ct_q[BW-M-1:0], ciphertxt};
          key_d   = {key_q[KW-N-1:0], key};
          cnt_d   = CW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (start) begin
          ct_d  = {ct_q[BW-M-1:0], ciphertxt};
          key_d = {key_q[KW-N-1:0], key};
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = EXPAND;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      EXPAND: begin
        key_d = {exp_new, key_q[63:16]};
        if (cnt_q == LAST_EXP) begin
          cnt_d   = LAST_RND;
          state_d = DECRYPT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DECRYPT: begin
        ct_d = rnd_data;
        if (cnt_q == '0) begin
          // Final round: first plaintext nibble leaves on the same edge
          ct_d    = {rnd_data[BW-M-1:0], {M{1'b0}}};
          plain_d = rnd_data[BW-1 -: M];
          valid_d = 1'b1;
          state_d = OUTPUT;
        end else begin
          key_d = {key_q[47:0], bwd_prev};
          cnt_d = cnt_q - CW'(1);
        end
      end
      OUTPUT: begin
        if (cnt_q == LAST_BEAT) begin
          plain_d = '0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          plain_d = ct_q[BW-1 -: M];
          ct_d    = {ct_q[BW-M-1:0], {M{1'b0}}};
          valid_d = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ct_q    <= '0;
      key_q   <= '0;
      plain_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
      key_q   <= key_d;
      plain_q <= plain_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign plain       = plain_q;
  assign plain_valid = valid_q;
  assign done_final  = done_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_simon_decrypt.sv
// Bench for simon_decrypt: vector table, latency/abort/short-load/busy-start sequences,
// and random round trips through a reference Simon32/64 encrypt/decrypt model.
module tb_simon_decrypt;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key;
  logic [3:0] ciphertxt;
  logic       start;
  logic [3:0] plain;
  logic       plain_valid;
  logic       busy;
  logic       done_final;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] KAT_K = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_C = 32'hc69b_e9bb;
  localparam logic [31:0] KAT_P = 32'h6565_6877;

  typedef struct {
    logic [63:0] key;
    logic [31:0] ct;
    logic [31:0] pt;
  } vec_t;

  vec_t vecs[4];

  simon_decrypt dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .ciphertxt  (ciphertxt),
    .start      (start),
    .plain      (plain),
    .plain_valid(plain_valid),
    .busy       (busy),
    .done_final (done_final)
  );

  always #5 clk = ~clk;

  // Reference model
  function automatic logic [15:0] rol(input logic [15:0] v, input int s);
    logic [31:0] d;
    d = {v, v} << s;
    return d[31:16];
  endfunction

  function automatic logic [15:0] ff(input logic [15:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  function automatic void expand(input logic [63:0] k64, output logic [15:0] k[32]);
    logic [61:0] z;
    logic [15:0] t;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = k64[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      t = rol(k[i+3], 13) ^ k[i+1];
      t = t ^ rol(t, 15);
      k[i+4] = ~k[i] ^ t ^ {15'b0, z[61-i]} ^ 16'h0003;
    end
  endfunction

  function automatic logic [31:0] simon_enc(input logic [63:0] k64, input logic [31:0] p);
    logic [15:0] k[32];
    logic [15:0] x, y, t;
    expand(k64, k);
    x = p[31:16];
    y = p[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ ff(x) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [31:0] simon_dec(input logic [63:0] k64, input logic [31:0] c);
    logic [15:0] k[32];
    logic [15:0] x, y, t;
    expand(k64, k);
    x = c[31:16];
    y = c[15:0];
    for (int i = 31; i >= 0; i--) begin
      t = y;
      y = x ^ ff(y) ^ k[i];
      x = t;
    end
    return {x, y};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Presents nb beats; returns at the falling edge after the last beat was sampled
  task automatic load(input logic [63:0] k, input logic [31:0] c, input int nb);
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      start     = 1'b1;
      key       = k[63-8*b -: 8];
      ciphertxt = c[31-4*b -: 4];
    end
    @(negedge clk);
    start     = 1'b0;
    key       = '0;
    ciphertxt = '0;
  endtask

  task automatic run_op(input logic [63:0] k, input logic [31:0] c, input logic [31:0] exp,
                        input bit garbage, input string tag);
    logic [31:0] pt;
    int n;
    int nv;
    load(k, c, 8);
    n = 0;
    while (!plain_valid && n < 200) begin
      if (garbage) begin
        start     = 1'($urandom);
        key       = 8'($urandom);
        ciphertxt = 4'($urandom);
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start     = 1'b0;
    key       = '0;
    ciphertxt = '0;
    check({tag, " latency"}, 64'(n), 64'd60);
    pt = '0;
    nv = 0;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      pt = {pt[27:0], plain};
      if (plain_valid) nv++;
    end
    check({tag, " valid_cycles"}, 64'(nv), 64'd8);
    check({tag, " plaintext"}, 64'(pt), 64'(exp));
    @(negedge clk);
    check({tag, " done_pulse"}, {62'b0, done_final, plain_valid}, 64'b10);
    @(negedge clk);
    check({tag, " idle_after"}, {61'b0, done_final, busy, plain_valid}, 64'b0);
  endtask

  task automatic count_valid(input int cycles, output int nv);
    nv = 0;
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      if (plain_valid) nv++;
    end
  endtask

  initial begin
    int nv;
    logic [63:0] rk;
    logic [31:0] rp;

    reset     = 1'b1;
    start     = 1'b0;
    key       = '0;
    ciphertxt = '0;
    #2;
    check("reset outputs", {57'b0, plain, plain_valid, busy, done_final}, 64'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle after reset", {57'b0, plain, plain_valid, busy, done_final}, 64'b0);
    check("model kat", 64'(simon_enc(KAT_K, KAT_P)), 64'(KAT_C));

    vecs[0] = '{KAT_K, KAT_C, KAT_P};
    vecs[1].key = {$urandom, $urandom};
    vecs[1].ct  = $urandom;
    vecs[1].pt  = simon_dec(vecs[1].key, vecs[1].ct);
    vecs[2].key = {$urandom, $urandom};
    vecs[2].ct  = 32'hffff_ffff;
    vecs[2].pt  = simon_dec(vecs[2].key, vecs[2].ct);
    vecs[3].key = 64'hffff_ffff_ffff_ffff;
    vecs[3].pt  = 32'h0;
    vecs[3].ct  = simon_enc(vecs[3].key, vecs[3].pt);

    for (int v = 0; v < 4; v++)
      run_op(vecs[v].key, vecs[v].ct, vecs[v].pt, 1'b0, $sformatf("vec%0d", v));

    // Short load is discarded
    load(KAT_K, KAT_C, 5);
    @(negedge clk);
    check("short busy", {63'b0, busy}, 64'b0);
    count_valid(80, nv);
    check("short no valid", 64'(nv), 64'd0);
    run_op(KAT_K, KAT_C, KAT_P, 1'b0, "after_short");

    // Asynchronous abort 20 cycles into decryption
    load(KAT_K, KAT_C, 8);
    repeat (48) @(negedge clk);
    check("busy in decrypt", {62'b0, busy, plain_valid}, 64'b10);
    reset = 1'b1;
    #1;
    check("abort outputs", {57'b0, plain, plain_valid, busy, done_final}, 64'b0);
    @(negedge clk);
    reset = 1'b0;
    count_valid(80, nv);
    check("abort no valid", 64'(nv), 64'd0);
    run_op(KAT_K, KAT_C, KAT_P, 1'b0, "after_abort");

    // Start toggling while busy is ignored
    run_op(KAT_K, KAT_C, KAT_P, 1'b1, "garbage");

    for (int r = 0; r < 50; r++) begin
      rk = {$urandom, $urandom};
      rp = $urandom;
      run_op(rk, simon_enc(rk, rp), rp, (r % 5) == 0, $sformatf("rt%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
